// File: rtl/mux_4to1.sv
// mux_4to1: parameterised bit-select multiplexer.
// Y is the bit of D chosen by sel (combinational), Y_q is a registered copy
// with load enable, and sel_err flags a select index beyond the last input.
module mux_4to1 #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  sel,
  input  logic [NUM_IN-1:0] D,
  input  logic              en,
  output logic              Y,
  output logic              Y_q,
  output logic              sel_err
);

  // Reject configurations where sel cannot address every input, or the
  // input count is outside the supported range.
  if ((SEL_W > 31) || ((32'd1 << SEL_W) < NUM_IN)) begin : g_bad_sel_w
    $fatal(1, "mux_4to1: 2**SEL_W must be >= NUM_IN");
  end
  if ((NUM_IN < 2) || (NUM_IN > 256)) begin : g_bad_num_in
    $fatal(1, "mux_4to1: NUM_IN must be in 2..256");
  end

  // Full decode of sel: every index either hits an input or raises sel_err
  // with Y forced low, so no select value leaves Y unassigned.
  always_comb begin
    Y       = 1'b0;
    sel_err = 1'b1;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        Y       = D[i];
        sel_err = 1'b0;
      end
    end
  end

  // Registered copy of the selected bit; reset wins over the load enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y_q <= '0;
    end else if (en) begin
      Y_q <= Y;
    end
  end

endmodule

// File: tb/tb_mux_4to1.sv
// Testbench for mux_4to1: a default 4:1 instance and a 3-input instance
// (so the out-of-range select path exists) checked by a queue scoreboard.
module tb_mux_4to1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sel4 = '0;
  logic [3:0] d4   = '0;
  logic       en4  = 1'b0;
  logic [1:0] sel3 = '0;
  logic [2:0] d3   = '0;
  logic       en3  = 1'b0;
  logic       y4, yq4, err4;
  logic       y3, yq3, err3;

  mux_4to1 u4 (
    .clk(clk), .rst(rst), .sel(sel4), .D(d4), .en(en4),
    .Y(y4), .Y_q(yq4), .sel_err(err4)
  );

  mux_4to1 #(.NUM_IN(3), .SEL_W(2)) u3 (
    .clk(clk), .rst(rst), .sel(sel3), .D(d3), .en(en3),
    .Y(y3), .Y_q(yq3), .sel_err(err3)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  y4, yq4, err4;
    logic  y3, yq3, err3;
  } exp_t;

  exp_t exp_q[$];
  event smp;
  int   checks = 0;
  int   errors = 0;

  // Reference: selected bit is bit 'sel' of the data word, or 0 past the end.
  function automatic logic ref_y(int n, int s, int d);
    if (s >= n) return 1'b0;
    return ((d >> s) & 1) != 0;
  endfunction

  function automatic logic ref_err(int n, int s);
    return s >= n;
  endfunction

  // Reference registers: what each Y_q should hold after every rising edge.
  logic mq4 = 1'b0;
  logic mq3 = 1'b0;
  always @(posedge clk) begin
    mq4 <= rst ? 1'b0 : (en4 ? ref_y(4, int'(sel4), int'(d4)) : mq4);
    mq3 <= rst ? 1'b0 : (en3 ? ref_y(3, int'(sel3), int'(d3)) : mq3);
  end

  task automatic chk(input string name, input string field,
                     input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %b expected %b (t=%0t)", name, field, act, exp, $time);
    end
  endtask

  // Monitor: once outputs have settled, pop every pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(smp);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "Y4",       y4,   e.y4);
        chk(e.name, "Y_q4",     yq4,  e.yq4);
        chk(e.name, "sel_err4", err4, e.err4);
        chk(e.name, "Y3",       y3,   e.y3);
        chk(e.name, "Y_q3",     yq3,  e.yq3);
        chk(e.name, "sel_err3", err3, e.err3);
      end
    end
  end

  // Push the expected response for the current inputs and let the monitor check it.
  task automatic step(input string name);
    exp_t e;
    e.name = name;
    e.y4   = ref_y(4, int'(sel4), int'(d4));
    e.err4 = ref_err(4, int'(sel4));
    e.yq4  = mq4;
    e.y3   = ref_y(3, int'(sel3), int'(d3));
    e.err3 = ref_err(3, int'(sel3));
    e.yq3  = mq3;
    exp_q.push_back(e);
    ->smp;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: monitor did not consume expectation", name);
      exp_q.delete();
    end
  endtask

  // Apply a full input set just after a falling edge, then check.
  task automatic drive(input string name, input logic r,
                       input logic [1:0] s4, input logic [3:0] dd4, input logic e4,
                       input logic [1:0] s3, input logic [2:0] dd3, input logic e3);
    @(negedge clk);
    rst = r; sel4 = s4; d4 = dd4; en4 = e4; sel3 = s3; d3 = dd3; en3 = e3;
    step(name);
  endtask

  initial begin
    // Reset with en high and Y high: Y_q must clear, Y keeps working.
    rst = 1'b1; en4 = 1'b1; en3 = 1'b1;
    sel4 = 2'd3; d4 = 4'hF; sel3 = 2'd0; d3 = 3'b001;
    repeat (2) @(negedge clk);
    step("reset");

    // D=0110 stepped through every sel with loads disabled.
    for (int s = 0; s < 4; s++)
      drive("d0110_sweep", 1'b0, 2'(s), 4'b0110, 1'b0, 2'(s), 3'b110, 1'b0);

    // Exhaustive 4-input select, checked shortly after each change.
    for (int d = 0; d < 16; d++)
      for (int s = 0; s < 4; s++)
        drive("exhaustive", 1'b0, 2'(s), 4'(d), 1'b0, 2'(s), 3'(d), 1'b0);

    // Registered path: load D[3]=1, then hold while sel moves to a 0 bit.
    drive("load_setup",  1'b0, 2'd3, 4'b1000, 1'b1, 2'd2, 3'b111, 1'b1);
    drive("load_result", 1'b0, 2'd0, 4'b1000, 1'b0, 2'd2, 3'b111, 1'b0);
    drive("hold",        1'b0, 2'd0, 4'b1000, 1'b0, 2'd2, 3'b111, 1'b0);

    // Reset priority over en while Y=1.
    drive("rst_pri_pre",  1'b1, 2'd3, 4'b1000, 1'b1, 2'd2, 3'b111, 1'b1);
    drive("rst_pri_post", 1'b0, 2'd3, 4'b1000, 1'b0, 2'd2, 3'b111, 1'b0);

    // 3-input instance: load a 1, then an out-of-range select loads 0.
    drive("n3_sel2",      1'b0, 2'd0, 4'b0000, 1'b0, 2'd2, 3'b111, 1'b1);
    drive("n3_sel3",      1'b0, 2'd0, 4'b0000, 1'b0, 2'd3, 3'b111, 1'b1);
    drive("n3_sel3_load", 1'b0, 2'd0, 4'b0000, 1'b0, 2'd3, 3'b111, 1'b0);

    // D toggled under a fixed sel=01; Y follows without a clock edge.
    @(negedge clk);
    en4 = 1'b0; en3 = 1'b0; sel4 = 2'd1; sel3 = 2'd1;
    d4 = 4'b0000; d3 = 3'b000; #1 step("toggle_d0");
    d4 = 4'b0010; d3 = 3'b010; #1 step("toggle_d1");

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 300; i++)
      drive("random", ($urandom_range(0, 15) == 0),
            2'($urandom), 4'($urandom), 1'($urandom),
            2'($urandom), 3'($urandom), 1'($urandom));

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
